// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants for the MEM-stage data-memory sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_pkg;

   localparam int XLEN = 32;

   // ResultSrc encoding that selects memory read data for write-back
   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10,
      DONE = 2'b11
   } dmem_state_t;

   // A store or a load needs the data bus; a store with a load ResultSrc is still a store
   function automatic logic is_mem_access(input logic mem_write, input logic [1:0] result_src);
      return mem_write | (result_src == RESULT_SRC_MEM);
   endfunction

endpackage

// File: rtl/flop_en_rst_cl.sv
// Enabled register with synchronous clear to zero.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: none; en low simply holds the stored value.
module flop_en_rst_cl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Load on enable, clear on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Latency: 1 cycle from inc to updated q.
// Backpressure: none; increments while saturated are dropped.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   // Count up on inc until every bit is set, then hold
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency data bus; freezes the pipeline until the access ends.
// Latency: store = 2 stall cycles + DONE, load = 3 stall cycles + DONE at zero bus wait; +1 per wait cycle.
// Backpressure: waits in REQ for dmem_gnt and in RESP for dmem_rvalid, aborting after TIMEOUT cycles.
module dmem_access_ctrl #(
   parameter int XLEN    = riscv_pkg::XLEN,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MemWriteM,
   input  logic [1:0]       ResultSrcM,
   input  logic [XLEN-1:0]  ALUResultM,
   input  logic [XLEN-1:0]  WriteDataM,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   input  logic             dmem_gnt,
   input  logic             dmem_rvalid,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             StallMem,
   output logic             FlushW,
   output logic [XLEN-1:0]  ReadDataM,
   output logic             BusErr,
   output logic [CNT_W-1:0] StallCnt
);
   import riscv_pkg::*;

   // Last counter value at which the current wait state is allowed to run
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   dmem_state_t     state;
   logic [15:0]     tcnt;
   logic            access;
   logic            at_limit;
   logic            capture;
   logic            abort;
   logic            rd_en;
   logic [XLEN-1:0] rd_d;

   assign access   = is_mem_access(MemWriteM, ResultSrcM);
   assign at_limit = (tcnt == TO_LAST);
   // rvalid only counts while a load is waiting for it
   assign capture  = (state == RESP) && dmem_rvalid;
   // The exit condition always beats the timeout threshold
   assign abort    = at_limit && (((state == REQ)  && !dmem_gnt) ||
                                  ((state == RESP) && !dmem_rvalid));

   // Sequencer with registered request and error pulse; timeout counter runs in REQ and RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tcnt     <= '0;
         dmem_req <= 1'b0;
         BusErr   <= 1'b0;
      end else begin
         BusErr <= 1'b0;
         case (state)
            IDLE: begin
               if (access) begin
                  state    <= REQ;
                  dmem_req <= 1'b1;
                  tcnt     <= '0;
               end
            end
            REQ: begin
               tcnt <= tcnt + 16'd1;
               if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  state    <= MemWriteM ? DONE : RESP;
               end else if (abort) begin
                  dmem_req <= 1'b0;
                  state    <= DONE;
                  BusErr   <= 1'b1;
               end
            end
            RESP: begin
               tcnt <= tcnt + 16'd1;
               if (capture) begin
                  state <= DONE;
               end else if (abort) begin
                  state  <= DONE;
                  BusErr <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

   // Freeze upstream and bubble WB from the first sight of an access until DONE
   assign StallMem   = ((state == IDLE) && access) || (state == REQ) || (state == RESP);
   assign FlushW     = StallMem;
   assign dmem_we    = dmem_req & MemWriteM;
   assign dmem_addr  = ALUResultM;
   assign dmem_wdata = WriteDataM;

   // Load data is captured on rvalid; an abort deliberately leaves zero behind
   assign rd_en = capture | abort;
   assign rd_d  = capture ? dmem_rdata : '0;

   flop_en_rst_cl #(.WIDTH(XLEN)) u_rdata (
      .clk (clk),
      .rst (rst),
      .en  (rd_en),
      .d   (rd_d),
      .q   (ReadDataM)
   );

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (StallMem),
      .q   (StallCnt)
   );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random vs reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_access_ctrl;

   localparam int TO_A = 16;
   localparam int TO_B = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        MemWriteM = 1'b0;
   logic [1:0]  ResultSrcM = 2'b00;
   logic [31:0] ALUResultM = '0;
   logic [31:0] WriteDataM = '0;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;

   logic        a_req, a_we, a_stall, a_flush, a_berr;
   logic [31:0] a_addr, a_wdata, a_rd, a_cnt;
   logic        b_req, b_we, b_stall, b_flush, b_berr;
   logic [31:0] b_addr, b_wdata, b_rd;
   logic [2:0]  b_cnt;

   dmem_access_ctrl #(.XLEN(32), .TIMEOUT(TO_A), .CNT_W(32)) u_dut_a (
      .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .dmem_req(a_req), .dmem_we(a_we), .dmem_addr(a_addr), .dmem_wdata(a_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .StallMem(a_stall), .FlushW(a_flush), .ReadDataM(a_rd), .BusErr(a_berr), .StallCnt(a_cnt)
   );

   dmem_access_ctrl #(.XLEN(32), .TIMEOUT(TO_B), .CNT_W(3)) u_dut_b (
      .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .dmem_req(b_req), .dmem_we(b_we), .dmem_addr(b_addr), .dmem_wdata(b_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .StallMem(b_stall), .FlushW(b_flush), .ReadDataM(b_rd), .BusErr(b_berr), .StallCnt(b_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: transaction-level view per DUT ----------------
   // busy: a bus transaction is outstanding; granted: request accepted, waiting for data;
   // finishing: the release cycle; age: cycles spent waiting on the bus so far.
   bit          m_busy[2];
   bit          m_granted[2];
   bit          m_finishing[2];
   bit          m_err[2];
   int          m_age[2];
   logic [31:0] m_rd[2];
   longint      m_stalls[2];
   longint      m_cap[2] = '{64'hFFFF_FFFF, 64'd7};
   int          m_limit[2] = '{TO_A, TO_B};

   function automatic bit wants_mem();
      return MemWriteM || (ResultSrcM == 2'b01);
   endfunction

   function automatic bit exp_stall(input int i);
      return m_busy[i] || (!m_finishing[i] && wants_mem());
   endfunction

   function automatic bit exp_req(input int i);
      return m_busy[i] && !m_granted[i];
   endfunction

   // Advance both models across one clock edge using the inputs currently applied
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit st;
         bit ok;
         st = exp_stall(i);
         if (rst) begin
            m_busy[i] = 0; m_granted[i] = 0; m_finishing[i] = 0; m_err[i] = 0;
            m_age[i] = 0; m_rd[i] = '0; m_stalls[i] = 0;
         end else begin
            if (st && (m_stalls[i] < m_cap[i])) m_stalls[i] = m_stalls[i] + 1;
            m_err[i] = 0;
            if (m_finishing[i]) begin
               m_finishing[i] = 0;
            end else if (!m_busy[i]) begin
               if (wants_mem()) begin
                  m_busy[i] = 1; m_granted[i] = 0; m_age[i] = 0;
               end
            end else begin
               ok = m_granted[i] ? dmem_rvalid : dmem_gnt;
               if (ok && m_granted[i]) begin
                  m_rd[i] = dmem_rdata; m_busy[i] = 0; m_finishing[i] = 1;
               end else if (ok && MemWriteM) begin
                  m_busy[i] = 0; m_finishing[i] = 1;
               end else if (ok) begin
                  m_granted[i] = 1;
               end else if (m_age[i] == m_limit[i] - 1) begin
                  m_busy[i] = 0; m_finishing[i] = 1; m_rd[i] = '0; m_err[i] = 1;
               end
               m_age[i]++;
            end
         end
      end
   endtask

   // One clock: commit the model for the held inputs, then apply new inputs after the negedge
   task automatic cyc_raw(input bit r, input bit mw, input logic [1:0] rs, input logic [31:0] ad,
                          input logic [31:0] wd, input bit g, input bit v, input logic [31:0] d);
      model_step();
      @(negedge clk);
      rst = r; MemWriteM = mw; ResultSrcM = rs; ALUResultM = ad; WriteDataM = wd;
      dmem_gnt = g; dmem_rvalid = v; dmem_rdata = d;
      #1;
   endtask

   // kind: 0 = no access, 1 = store, 2 = load
   task automatic cyc(input bit r, input int kind, input logic [31:0] ad, input logic [31:0] wd,
                      input bit g, input bit v, input logic [31:0] d);
      cyc_raw(r, kind == 1, (kind == 2) ? 2'b01 : 2'b00, ad, wd, g, v, d);
   endtask

   task automatic chk_model(input int i);
      bit          s, q, w, e, f;
      logic [31:0] rd, ad, cnt;
      if (i == 0) begin
         s = a_stall; f = a_flush; q = a_req; w = a_we; e = a_berr; rd = a_rd; ad = a_addr; cnt = a_cnt;
      end else begin
         s = b_stall; f = b_flush; q = b_req; w = b_we; e = b_berr; rd = b_rd; ad = b_addr; cnt = {29'd0, b_cnt};
      end
      chk($sformatf("rnd%0d stall", i), s, exp_stall(i));
      chk($sformatf("rnd%0d flush", i), f, exp_stall(i));
      chk($sformatf("rnd%0d req", i), q, exp_req(i));
      if (exp_req(i)) chk($sformatf("rnd%0d we", i), w, MemWriteM);
      chk($sformatf("rnd%0d berr", i), e, m_err[i]);
      chk($sformatf("rnd%0d rdata", i), rd, m_rd[i]);
      chk($sformatf("rnd%0d addr", i), ad, ALUResultM);
      chk($sformatf("rnd%0d cnt", i), cnt, m_stalls[i][31:0]);
   endtask

   // ---------------- directed vector table (DUT a, TIMEOUT=16) ----------------
   typedef struct {
      int          kind;
      logic [31:0] ad;
      logic [31:0] wd;
      bit          g;
      bit          v;
      logic [31:0] d;
      bit          e_req;
      bit          e_we;
      bit          e_stall;
      logic [31:0] e_rd;
      bit          e_berr;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input int kind, input logic [31:0] ad, input logic [31:0] wd,
                               input bit g, input bit v, input logic [31:0] d,
                               input bit er, input bit ew, input bit es, input logic [31:0] erd,
                               input bit eb, input logic [31:0] ec);
      vec_t t;
      t.kind = kind; t.ad = ad; t.wd = wd; t.g = g; t.v = v; t.d = d;
      t.e_req = er; t.e_we = ew; t.e_stall = es; t.e_rd = erd; t.e_berr = eb; t.e_cnt = ec;
      return t;
   endfunction

   vec_t tbl[21];

   initial begin
      bit hold;
      bit mw;
      logic [1:0] rs;
      logic [31:0] ad, wd;

      // store, gnt held high
      tbl[0]  = mk(1, 32'h100, 32'hDEADBEEF, 1, 0, 0,            0, 0, 1, 0,            0, 0);
      tbl[1]  = mk(1, 32'h100, 32'hDEADBEEF, 1, 0, 0,            1, 1, 1, 0,            0, 1);
      tbl[2]  = mk(1, 32'h100, 32'hDEADBEEF, 1, 0, 0,            0, 0, 0, 0,            0, 2);
      tbl[3]  = mk(0, 32'h0,   32'h0,        1, 0, 0,            0, 0, 0, 0,            0, 2);
      // load, gnt after 2 wait cycles, rvalid 3 cycles after gnt
      tbl[4]  = mk(2, 32'h200, 32'h0,        0, 0, 0,            0, 0, 1, 0,            0, 2);
      tbl[5]  = mk(2, 32'h200, 32'h0,        0, 0, 0,            1, 0, 1, 0,            0, 3);
      tbl[6]  = mk(2, 32'h200, 32'h0,        0, 0, 0,            1, 0, 1, 0,            0, 4);
      tbl[7]  = mk(2, 32'h200, 32'h0,        1, 0, 0,            1, 0, 1, 0,            0, 5);
      tbl[8]  = mk(2, 32'h200, 32'h0,        0, 0, 0,            0, 0, 1, 0,            0, 6);
      tbl[9]  = mk(2, 32'h200, 32'h0,        0, 0, 0,            0, 0, 1, 0,            0, 7);
      tbl[10] = mk(2, 32'h200, 32'h0,        0, 1, 32'h12345678, 0, 0, 1, 0,            0, 8);
      tbl[11] = mk(2, 32'h200, 32'h0,        0, 0, 0,            0, 0, 0, 32'h12345678, 0, 9);
      tbl[12] = mk(0, 32'h0,   32'h0,        0, 0, 0,            0, 0, 0, 32'h12345678, 0, 9);
      // back-to-back store then load with single-cycle memory
      tbl[13] = mk(1, 32'h300, 32'h0BADF00D, 0, 0, 0,            0, 0, 1, 32'h12345678, 0, 9);
      tbl[14] = mk(1, 32'h300, 32'h0BADF00D, 1, 0, 0,            1, 1, 1, 32'h12345678, 0, 10);
      tbl[15] = mk(1, 32'h300, 32'h0BADF00D, 0, 0, 0,            0, 0, 0, 32'h12345678, 0, 11);
      tbl[16] = mk(2, 32'h304, 32'h0,        0, 0, 0,            0, 0, 1, 32'h12345678, 0, 11);
      tbl[17] = mk(2, 32'h304, 32'h0,        1, 0, 0,            1, 0, 1, 32'h12345678, 0, 12);
      tbl[18] = mk(2, 32'h304, 32'h0,        0, 1, 32'hCAFEF00D, 0, 0, 1, 32'h12345678, 0, 13);
      tbl[19] = mk(2, 32'h304, 32'h0,        0, 0, 0,            0, 0, 0, 32'hCAFEF00D, 0, 14);
      tbl[20] = mk(0, 32'h0,   32'h0,        0, 0, 0,            0, 0, 0, 32'hCAFEF00D, 0, 14);

      // reset and check reset state
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("reset req", a_req, 0);
      chk("reset stall", a_stall, 0);
      chk("reset rdata", a_rd, 0);
      chk("reset berr", a_berr, 0);
      chk("reset cnt", a_cnt, 0);

      for (int i = 0; i < 21; i++) begin
         cyc(0, tbl[i].kind, tbl[i].ad, tbl[i].wd, tbl[i].g, tbl[i].v, tbl[i].d);
         chk($sformatf("tbl[%0d] stall", i), a_stall, tbl[i].e_stall);
         chk($sformatf("tbl[%0d] flush", i), a_flush, tbl[i].e_stall);
         chk($sformatf("tbl[%0d] req", i), a_req, tbl[i].e_req);
         if (tbl[i].e_req) chk($sformatf("tbl[%0d] we", i), a_we, tbl[i].e_we);
         chk($sformatf("tbl[%0d] addr", i), a_addr, tbl[i].ad);
         chk($sformatf("tbl[%0d] wdata", i), a_wdata, tbl[i].wd);
         chk($sformatf("tbl[%0d] rdata", i), a_rd, tbl[i].e_rd);
         chk($sformatf("tbl[%0d] berr", i), a_berr, tbl[i].e_berr);
         chk($sformatf("tbl[%0d] cnt", i), a_cnt, tbl[i].e_cnt);
      end

      // reset while waiting in RESP, followed by a late rvalid
      cyc(0, 2, 32'h400, 0, 1, 0, 0);
      chk("rstresp idle stall", a_stall, 1);
      cyc(0, 2, 32'h400, 0, 1, 0, 0);
      chk("rstresp req", a_req, 1);
      cyc(1, 2, 32'h400, 0, 0, 0, 0);
      chk("rstresp in resp stall", a_stall, 1);
      chk("rstresp in resp req", a_req, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
      chk("rstresp after req", a_req, 0);
      chk("rstresp after stall", a_stall, 0);
      chk("rstresp after rdata", a_rd, 0);
      chk("rstresp after berr", a_berr, 0);
      chk("rstresp after cnt", a_cnt, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
      chk("rstresp late rvalid rdata", a_rd, 0);
      chk("rstresp late rvalid stall", a_stall, 0);

      // timeout on DUT b (TIMEOUT=4): first a good load leaves nonzero data
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 2, 32'h500, 0, 1, 0, 0);
      cyc(0, 2, 32'h500, 0, 1, 0, 0);
      chk("to good req", b_req, 1);
      cyc(0, 2, 32'h500, 0, 0, 1, 32'h55AA55AA);
      chk("to good resp stall", b_stall, 1);
      cyc(0, 2, 32'h500, 0, 0, 0, 0);
      chk("to good done rdata", b_rd, 32'h55AA55AA);
      chk("to good done stall", b_stall, 0);
      chk("to good done berr", b_berr, 0);
      cyc(0, 2, 32'h600, 0, 0, 0, 0);
      chk("to idle stall", b_stall, 1);
      chk("to idle req", b_req, 0);
      for (int j = 0; j < TO_B; j++) begin
         cyc(0, 2, 32'h600, 0, 0, 0, 0);
         chk($sformatf("to wait%0d req", j), b_req, 1);
         chk($sformatf("to wait%0d berr", j), b_berr, 0);
      end
      cyc(0, 2, 32'h600, 0, 0, 0, 0);
      chk("to done req", b_req, 0);
      chk("to done berr", b_berr, 1);
      chk("to done rdata", b_rd, 0);
      chk("to done stall", b_stall, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("to after berr", b_berr, 0);
      chk("to after stall", b_stall, 0);

      // stall counter saturation on DUT b (CNT_W=3): two timed-out loads give 10 stall cycles
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 12; k++) begin
         cyc(0, 2, 32'h700, 0, 0, 0, 0);
         if (k == 5) begin
            chk("sat cnt at 5", b_cnt, 5);
            chk("sat berr first", b_berr, 1);
         end
         if (k == 8) chk("sat cnt reaches 7", b_cnt, 7);
         if (k == 11) begin
            chk("sat cnt holds 7", b_cnt, 7);
            chk("sat berr second", b_berr, 1);
         end
      end

      // randomized traffic against the reference model for both DUTs
      cyc(1, 0, 0, 0, 0, 0, 0);
      mw = 0; rs = 0; ad = 0; wd = 0;
      for (int n = 0; n < 3000; n++) begin
         hold = exp_stall(0) && !rst;
         if (!hold) begin
            mw = ($urandom_range(0, 2) == 0);
            rs = 2'($urandom_range(0, 3));
            ad = $urandom;
            wd = $urandom;
         end
         cyc_raw($urandom_range(0, 63) == 0, mw, rs, ad, wd,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom);
         chk_model(0);
         chk_model(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for the MEM stage of the RV32I pipeline when data memory has a variable-latency request/response bus. It watches the control and data leaving the EX/MEM pipeline register, issues the bus transaction, and freezes the whole pipeline until the access completes. While frozen it bubbles MEM/WB, then returns load data aligned with release. A timeout turns a hung bus into a bus-error pulse, and a saturating counter records memory stall cycles.

## Interface
Parameters:
- XLEN, riscv_pkg::XLEN (32): data/address width
- TIMEOUT, 255: cycles in REQ+RESP before abort; legal range 1..65535
- CNT_W, 32: stall-counter width

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset; synchronous, active-high
- MemWriteM  in  1  store in MEM stage
- ResultSrcM  in  2  load when equal to RESULT_SRC_MEM (2'b01)
- ALUResultM  in  XLEN  byte address
- WriteDataM  in  XLEN  store data
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  address, equal to ALUResultM
- dmem_wdata  out  XLEN  store data, equal to WriteDataM
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  read data
- StallMem  out  1  deasserts en on PC, IF/ID, ID/EX and EX/MEM registers
- FlushW  out  1  clears MEM/WB register
- ReadDataM  out  XLEN  captured load data
- BusErr  out  1  one-cycle abort pulse
- StallCnt  out  CNT_W  saturating count of StallMem cycles

## Operation
- Access: MemWriteM | (ResultSrcM == RESULT_SRC_MEM); both set is a store.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - With an access present: StallMem=1, next state REQ.
  - Otherwise: StallMem=0, stay in IDLE.
- REQ:
  - dmem_req=1 and dmem_we=MemWriteM.
  - On dmem_gnt: a store goes to DONE, a load goes to RESP.
  - Without dmem_gnt: stay in REQ.
- RESP:
  - dmem_req=0.
  - On dmem_rvalid: capture dmem_rdata into ReadDataM, go to DONE.
- DONE:
  - StallMem=0, so the instruction advances to WB at this edge.
  - Next state IDLE.
- StallMem=1 in IDLE-with-access, REQ and RESP.
- FlushW equals StallMem.
- dmem_rvalid is ignored outside RESP. dmem_gnt is ignored outside REQ.
- Timeout:
  - A counter clears on IDLE→REQ and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT-1 and the exit condition for the current state is false, go to DONE. ReadDataM is loaded with 0 and BusErr=1 during DONE.
- StallCnt increments on every StallMem=1 cycle and holds at all-ones.
- dmem_addr and dmem_wdata are combinational pass-throughs. They are valid only when dmem_req=1.
- ReadDataM holds its value until the next capture, timeout load or reset.

## Timing
- Reset (synchronous): state=IDLE, timeout counter=0, ReadDataM=0, StallCnt=0, BusErr=0. dmem_req=0 from the first cycle after the reset edge.
- Reset mid-transaction aborts with no completion. A late dmem_rvalid after reset is ignored.
- Store with immediate gnt: 2 stall cycles (IDLE, REQ), then DONE. The instruction occupies MEM for 3 cycles.
- Load with immediate gnt and rvalid on the next cycle: 3 stall cycles, then DONE, for 4 cycles in MEM. ReadDataM is valid in DONE.
- Each extra cycle of gnt or rvalid delay adds exactly one stall cycle.
- A new access in MEM the cycle after DONE is seen in IDLE. Back-to-back accesses have no dead cycle beyond the FSM sequence.
- Abort timing: when the exit condition is still false, the FSM leaves REQ or RESP for DONE TIMEOUT cycles after IDLE→REQ. The state and cycle where the exit condition first evaluates false are fixed in the implementation.
- Simultaneous gnt and timeout threshold: gnt wins.
- Simultaneous rvalid and timeout threshold: rvalid wins and no BusErr is raised.
- Memory must not raise rvalid in the same cycle as gnt; such an rvalid is ignored.

## Structure
- riscv_pkg receives:
  - typedef enum logic [1:0] dmem_state_t {IDLE, REQ, RESP, DONE}
  - localparam RESULT_SRC_MEM = 2'b01
- The ReadDataM capture uses the existing flop_en_rst_cl:
  - en = capture or abort
  - d = rvalid ? rdata : 0
- One new sub-module, sat_counter: parameter WIDTH, ports clk, rst, inc, q. Used for StallCnt.
- FSM and timeout counter are inline.

## Test plan
- Store, addr 0x100, data 0xDEADBEEF, gnt held high → dmem_req for exactly 1 cycle with we=1, StallMem high for 2 cycles, StallCnt=2.
- Load, addr 0x200, gnt after 2 wait cycles, rvalid 3 cycles after gnt with rdata 0x12345678 → StallMem high for 7 cycles, ReadDataM=0x12345678 in DONE, FlushW equal to StallMem every cycle.
- Load with no gnt and TIMEOUT=4 → DONE 4 cycles after entering REQ, BusErr pulses once, ReadDataM=0, dmem_req low in DONE.
- rst asserted while in RESP, then rvalid pulsed → state IDLE, outputs at reset values, ReadDataM stays 0.
- CNT_W=3 with 10 stall cycles → StallCnt saturates at 7.
- Back-to-back store then load, 1-cycle memory → no idle gap; second IDLE stall begins the cycle after the first DONE.
